tour_cmd: RTL



---
 rtl/tour_pkg.sv | 88 ++++++++
 rtl/tour_cmd.sv | 115 +++++++++++
 2 files changed

// File: rtl/tour_pkg.sv
// Shared types, constants and the move decoder
// for the knight's-tour command replayer.
package tour_pkg;

  localparam int NUM_MOVES = 24;
  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  localparam logic [3:0] OP_MOVE     = 4'b0010;
  localparam logic [3:0] OP_MOVE_FAN = 4'b0011;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  typedef struct packed {
    logic [15:0] vert;
    logic [15:0] horz;
  } tour_cmds_t;

  // Lowest set bit wins; an empty move degenerates to zero-square moves.
  function automatic tour_cmds_t move_decode(
    input logic [7:0] mv
  );
    tour_cmds_t c;
    logic [7:0] vh;
    logic [7:0] hh;
    logic [3:0] vs;
    logic [3:0] hs;
    vh = NORTH;
    hh = EAST;
    vs = 4'd0;
    hs = 4'd0;
    casez (mv)
      8'b???????1: begin
        vh = NORTH; vs = 4'd2;
        hh = WEST;  hs = 4'd1;
      end
      8'b??????10: begin
        vh = NORTH; vs = 4'd2;
        hh = EAST;  hs = 4'd1;
      end
      8'b?????100: begin
        vh = NORTH; vs = 4'd1;
        hh = WEST;  hs = 4'd2;
      end
      8'b????1000: begin
        vh = SOUTH; vs = 4'd1;
        hh = WEST;  hs = 4'd2;
      end
      8'b???10000: begin
        vh = SOUTH; vs = 4'd2;
        hh = WEST;  hs = 4'd1;
      end
      8'b??100000: begin
        vh = SOUTH; vs = 4'd2;
        hh = EAST;  hs = 4'd1;
      end
      8'b?1000000: begin
        vh = SOUTH; vs = 4'd1;
        hh = EAST;  hs = 4'd2;
      end
      8'b10000000: begin
        vh = NORTH; vs = 4'd1;
        hh = EAST;  hs = 4'd2;
      end
      default: begin
        vh = NORTH; vs = 4'd0;
        hh = EAST;  hs = 4'd0;
      end
    endcase
    c.vert = {OP_MOVE, vh, vs};
    c.horz = {OP_MOVE_FAN, hh, hs};
    return c;
  endfunction

endpackage

// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as vertical/horizontal
// robot commands, muxed with the UART command path.
module tour_cmd
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  output logic        clr_cmd_rdy_UART,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp
);

  state_t     r_state;
  logic [4:0] r_mv_indx;
  tour_cmds_t w_cmds;
  logic       w_last;

  assign w_cmds  = move_decode(move);
  assign w_last  = (r_mv_indx == LAST_IDX);
  assign mv_indx = r_mv_indx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mv_indx <= 5'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_tour) begin
            r_state   <= VERT;
            r_mv_indx <= 5'd0;
          end
        end
        VERT: begin
          if (clr_cmd_rdy)
            r_state <= WAIT_V;
        end
        WAIT_V: begin
          if (send_resp)
            r_state <= HORZ;
        end
        HORZ: begin
          if (clr_cmd_rdy)
            r_state <= WAIT_H;
        end
        WAIT_H: begin
          if (send_resp) begin
            if (w_last) begin
              r_state   <= IDLE;
              r_mv_indx <= 5'd0;
            end else begin
              r_state   <= VERT;
              r_mv_indx <= r_mv_indx + 5'd1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mv_indx <= 5'd0;
        end
      endcase
    end
  end

  // IDLE is a transparent path: the UART ack must land in the same cycle.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    unique case (r_state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
      end
      VERT: begin
        cmd              = w_cmds.vert;
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = 1'b0;
      end
      WAIT_V: begin
        cmd              = w_cmds.vert;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
      end
      HORZ: begin
        cmd              = w_cmds.horz;
        cmd_rdy          = 1'b1;
        clr_cmd_rdy_UART = 1'b0;
      end
      WAIT_H: begin
        cmd              = w_cmds.horz;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
      end
      default: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
      end
    endcase
  end

  assign resp = (r_state == WAIT_H && w_last)
              ? RESP_DONE : RESP_ACK;

endmodule
